// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_t : FSM state encoding (2'd3 is unused and recovers to IDLE)
//   REQ_CORE    : requester index of the multicycle core (fetch, load/store)
//   REQ_DBG     : requester index of the debug/boot loader
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory wrapper.
//   req/we/addr/wdata : per-requester request fields, requester n at [n*W +: W]
//   ack/err/rdata     : per-requester completion pulse, timeout flag, read data
//   mem_*             : single memory port (strobe, write enable, address,
//                       write data, read data, completion)
// modport master : arbiter side
// modport slave  : requester/memory side
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [1:0]      req;
  logic [1:0]      we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      ack;
  logic            err;
  logic [DW-1:0]   rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;

  modport master (
    input  req, we, addr, wdata, mem_rdata, mem_ready,
    output ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req, we, addr, wdata, mem_rdata, mem_ready,
    input  ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way request picker.
//   req        : request bits, index = requester id
//   last       : requester granted most recently
//   fixed_prio : 1 = core wins every conflict, 0 = alternate on conflicts
//   valid      : at least one request present
//   winner     : granted requester id (REQ_CORE when nothing requests)
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed_prio,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = REQ_CORE;
    case (req)
      2'b10:   winner = REQ_DBG;
      2'b11:   winner = fixed_prio ? REQ_CORE : ~last;
      default: winner = REQ_CORE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the unified instruction/data memory between the core
// (requester 0) and the debug/boot loader (requester 1). Each access runs
// IDLE -> ACCESS -> DONE; a hung access is aborted after TIMEOUT cycles and
// acked with err set.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : requester and memory signals (mem_port_arbiter_if.master)
//   owner : granted requester, meaningful in ACCESS/DONE
//   state : FSM state for debug
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int TIMEOUT   = 15,
  parameter int PRIO_CORE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.master   bus,
  output logic                 owner,
  output logic [1:0]           state
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t     cur_st, nxt_st;
  logic           rr_last, rr_n;
  logic           owner_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           mreq_n, mwe_n, err_n;
  logic [AW-1:0]  maddr_n;
  logic [DW-1:0]  mwd_n, rdata_n;
  logic [1:0]     ack_n;
  logic           pick_valid, pick_win;

  rr_pick2 u_pick (
    .req        (bus.req),
    .last       (rr_last),
    .fixed_prio (PRIO_CORE != 0),
    .valid      (pick_valid),
    .winner     (pick_win)
  );

  always_comb begin
    nxt_st  = cur_st;
    rr_n    = rr_last;
    owner_n = owner;
    cnt_n   = cnt;
    mreq_n  = bus.mem_req;
    mwe_n   = bus.mem_we;
    maddr_n = bus.mem_addr;
    mwd_n   = bus.mem_wdata;
    rdata_n = bus.rdata;
    ack_n   = '0;
    err_n   = 1'b0;
    case (cur_st)
      IDLE: begin
        if (pick_valid) begin
          rr_n    = pick_win;
          owner_n = pick_win;
          mwe_n   = bus.we[pick_win];
          maddr_n = pick_win ? bus.addr[2*AW-1:AW]  : bus.addr[AW-1:0];
          mwd_n   = pick_win ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
          mreq_n  = 1'b1;
          cnt_n   = '0;
          nxt_st  = ACCESS;
        end
      end
      ACCESS: begin
        // Ready is tested first so it wins over an abort in the same cycle.
        if (bus.mem_ready) begin
          rdata_n       = bus.mem_we ? '0 : bus.mem_rdata;
          ack_n[owner]  = 1'b1;
          mreq_n        = 1'b0;
          nxt_st        = DONE;
        end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
          rdata_n       = '0;
          ack_n[owner]  = 1'b1;
          err_n         = 1'b1;
          mreq_n        = 1'b0;
          nxt_st        = DONE;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: nxt_st = IDLE;
      default: begin
        nxt_st = IDLE;
        mreq_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st        <= IDLE;
      rr_last       <= 1'b1;
      owner         <= 1'b0;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rdata     <= '0;
      bus.ack       <= '0;
      bus.err       <= 1'b0;
    end else begin
      cur_st        <= nxt_st;
      rr_last       <= rr_n;
      owner         <= owner_n;
      cnt           <= cnt_n;
      bus.mem_req   <= mreq_n;
      bus.mem_we    <= mwe_n;
      bus.mem_addr  <= maddr_n;
      bus.mem_wdata <= mwd_n;
      bus.rdata     <= rdata_n;
      bus.ack       <= ack_n;
      bus.err       <= err_n;
    end
  end

  assign state = cur_st;

endmodule
